// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, pattern encodings and the
// pattern-sequencer state type.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = 800;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = 525;

    localparam int unsigned PAT_W = 2;

    typedef enum logic [PAT_W-1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_CIRCLE   = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        HOLD   = 2'd2
    } seq_state_e;

    // Advance a pattern index, wrapping back to 0 after num_patterns-1.
    function automatic logic [PAT_W-1:0] wrap_inc(input logic [PAT_W-1:0] p,
                                                  input int unsigned      num_patterns);
        if (p == PAT_W'(num_patterns - 1)) begin
            return '0;
        end
        return p + PAT_W'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, consecutive-sample debouncer
// and a one-cycle pulse on each debounced press (release gives no pulse).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_pix,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          press_q;

    // Any sample agreeing with the accepted level reloads the counter.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_raw};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Pattern-select front end for the VGA generator: manual / auto-cycle / hold
// modes, with the selected pattern applied only at frame start.
module vga_pattern_sequencer
    import vga_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 250000,
    parameter int unsigned FRAMES_PER_PATTERN = 120,
    parameter int unsigned NUM_PATTERNS       = 4
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             btn_next,
    input  logic             btn_mode,
    input  logic [PAT_W-1:0] sw,
    input  logic             vga_vsync,
    output logic [PAT_W-1:0] pattern_sel,
    output logic             auto_mode,
    output logic             frame_tick
);

    localparam int unsigned FCW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

    logic next_press, mode_press;
    logic next_level, mode_level;
    logic unused_levels;

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pending_q, pending_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic [PAT_W-1:0] pattern_sel_q, pattern_sel_d;
    logic             auto_mode_q, auto_mode_d;
    logic             vsync_q;
    logic             frame_tick_q, frame_tick_d;
    logic             expire;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk_pix (clk_pix),
        .rst     (rst),
        .btn_raw (btn_next),
        .level   (next_level),
        .press   (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_pix (clk_pix),
        .rst     (rst),
        .btn_raw (btn_mode),
        .level   (mode_level),
        .press   (mode_press)
    );

    assign unused_levels = next_level ^ mode_level;

    assign expire = frame_tick_q && (fcnt_q == FCW'(FRAMES_PER_PATTERN - 1));

    // Mode press wins over a same-cycle next press; the pattern output samples
    // the pre-update pending value on the tick cycle.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        fcnt_d        = fcnt_q;
        frame_tick_d  = vsync_q & ~vga_vsync;
        pattern_sel_d = frame_tick_q ? pending_q : pattern_sel_q;

        unique case (state_q)
            MANUAL: begin
                pending_d = sw;
                if (mode_press) begin
                    state_d = AUTO;
                    fcnt_d  = '0;
                end
            end
            AUTO: begin
                if (mode_press) begin
                    state_d = HOLD;
                end else if (next_press || expire) begin
                    pending_d = wrap_inc(pending_q, NUM_PATTERNS);
                    fcnt_d    = '0;
                end else if (frame_tick_q) begin
                    fcnt_d = fcnt_q + FCW'(1);
                end
            end
            HOLD: begin
                if (mode_press) begin
                    state_d   = MANUAL;
                    pending_d = sw;
                end else if (next_press) begin
                    pending_d = wrap_inc(pending_q, NUM_PATTERNS);
                end
            end
            default: begin
                state_d = MANUAL;
            end
        endcase

        auto_mode_d = (state_d == AUTO);
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q       <= MANUAL;
            pending_q     <= PAT_BARS;
            fcnt_q        <= '0;
            pattern_sel_q <= PAT_BARS;
            auto_mode_q   <= 1'b0;
            vsync_q       <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            fcnt_q        <= fcnt_d;
            pattern_sel_q <= pattern_sel_d;
            auto_mode_q   <= auto_mode_d;
            vsync_q       <= vga_vsync;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign pattern_sel = pattern_sel_q;
    assign auto_mode   = auto_mode_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scenario bench for vga_pattern_sequencer with a short debounce and a
// 3-frame auto period; expected pattern_sel per frame is queued and popped.
module tb_vga_pattern_sequencer;

    logic       clk_pix = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       btn_mode;
    logic [1:0] sw;
    logic       vga_vsync = 1'b1;
    logic [1:0] pattern_sel;
    logic       auto_mode;
    logic       frame_tick;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];
    int         vcnt = 0;

    vga_pattern_sequencer #(
        .DEBOUNCE_CYCLES    (4),
        .FRAMES_PER_PATTERN (3),
        .NUM_PATTERNS       (4)
    ) dut (
        .clk_pix     (clk_pix),
        .rst         (rst),
        .btn_next    (btn_next),
        .btn_mode    (btn_mode),
        .sw          (sw),
        .vga_vsync   (vga_vsync),
        .pattern_sel (pattern_sel),
        .auto_mode   (auto_mode),
        .frame_tick  (frame_tick)
    );

    always #5 clk_pix = ~clk_pix;

    // vsync low for 2 cycles out of every 40
    initial begin
        forever begin
            @(posedge clk_pix);
            #1;
            vcnt      = (vcnt + 1) % 40;
            vga_vsync = !(vcnt == 20 || vcnt == 21);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    // Wait for a frame tick, then check pattern_sel one edge later against the queue head.
    task automatic wait_tick_check(input string name);
        bit         seen;
        logic [1:0] exp;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: frame_tick got none in 100 cycles, expected a tick", name);
            return;
        end
        step(1);
        if (pattern_sel !== exp) begin
            n_err++;
            $display("FAIL %s: pattern_sel got %0d expected %0d", name, pattern_sel, exp);
        end
    endtask

    task automatic press_btn(input bit is_mode);
        if (is_mode) btn_mode = 1'b1; else btn_next = 1'b1;
        step(10);
        if (is_mode) btn_mode = 1'b0; else btn_next = 1'b0;
        step(10);
    endtask

    task automatic check_auto(input string name, input logic exp);
        n_vec++;
        if (auto_mode !== exp) begin
            n_err++;
            $display("FAIL %s: auto_mode got %0b expected %0b", name, auto_mode, exp);
        end
    endtask

    // Counts edges from driving a held button until auto_mode rises.
    task automatic check_latency(input string name, input int exp_edges);
        int got;
        got = -1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (auto_mode === 1'b1) begin
                got = k;
                break;
            end
        end
        n_vec++;
        if (got != exp_edges) begin
            n_err++;
            $display("FAIL %s: edges to auto_mode got %0d expected %0d", name, got, exp_edges);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_mode = 1'b0;
        sw       = 2'd0;
        step(3);
        n_vec += 2;
        if (pattern_sel !== 2'd0) begin
            n_err++;
            $display("FAIL reset_sel: pattern_sel got %0d expected 0", pattern_sel);
        end
        if (frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tick: frame_tick got %0b expected 0", frame_tick);
        end
        check_auto("reset_auto", 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_manual();
        sw = 2'd2;
        step(1);
        n_vec++;
        if (pattern_sel !== 2'd0) begin
            n_err++;
            $display("FAIL manual_before_tick: pattern_sel got %0d expected 0", pattern_sel);
        end
        exp_q.push_back(2'd2);
        wait_tick_check("manual_sw2");
        check_auto("manual_auto", 1'b0);
        sw = 2'd3;
        exp_q.push_back(2'd3);
        wait_tick_check("manual_sw3");
    endtask

    task automatic test_bounce();
        btn_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_mode = ~btn_mode;
            step(2);
        end
        btn_mode = 1'b1;
        check_latency("bounce_latency", 8);
        step(2);
        btn_mode = 1'b0;
        step(8);
        check_auto("bounce_single_press", 1'b1);
    endtask

    task automatic test_auto();
        logic [1:0] seq [9] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        foreach (seq[i]) exp_q.push_back(seq[i]);
        for (int i = 0; i < 9; i++) wait_tick_check($sformatf("auto_frame%0d", i));
        check_auto("auto_still_auto", 1'b1);
    endtask

    task automatic test_hold_midframe();
        press_btn(1'b1);
        check_auto("hold_entered", 1'b0);
        exp_q.push_back(2'd2);
        wait_tick_check("hold_first");
        step(8);
        press_btn(1'b0);
        n_vec++;
        if (pattern_sel !== 2'd2) begin
            n_err++;
            $display("FAIL hold_midframe: pattern_sel got %0d expected 2", pattern_sel);
        end
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd3);
        for (int i = 0; i < 3; i++) wait_tick_check($sformatf("hold_after_next%0d", i));
    endtask

    task automatic test_simultaneous();
        sw = 2'd1;
        press_btn(1'b1);
        check_auto("sim_to_manual", 1'b0);
        exp_q.push_back(2'd1);
        wait_tick_check("sim_manual_sel");
        press_btn(1'b1);
        check_auto("sim_to_auto", 1'b1);
        exp_q.push_back(2'd1);
        wait_tick_check("sim_auto_sel");
        btn_mode = 1'b1;
        btn_next = 1'b1;
        step(10);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        step(10);
        check_auto("sim_to_hold", 1'b0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        wait_tick_check("sim_hold_sel0");
        wait_tick_check("sim_hold_sel1");
    endtask

    task automatic test_reset_midcount();
        sw = 2'd2;
        press_btn(1'b1);
        exp_q.push_back(2'd2);
        wait_tick_check("rmid_manual_sel");
        press_btn(1'b1);
        check_auto("rmid_auto", 1'b1);
        exp_q.push_back(2'd2);
        wait_tick_check("rmid_auto_sel");
        btn_mode = 1'b1;
        step(4);
        rst = 1'b1;
        step(2);
        n_vec += 2;
        if (pattern_sel !== 2'd0) begin
            n_err++;
            $display("FAIL rmid_sel: pattern_sel got %0d expected 0", pattern_sel);
        end
        if (frame_tick !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_tick: frame_tick got %0b expected 0", frame_tick);
        end
        check_auto("rmid_auto_cleared", 1'b0);
        rst = 1'b0;
        check_latency("rmid_full_debounce", 8);
        btn_mode = 1'b0;
        step(10);
        exp_q.push_back(2'd2);
        wait_tick_check("rmid_after_sel");
    endtask

    initial begin
        test_reset();
        test_manual();
        test_bounce();
        test_auto();
        test_hold_midframe();
        test_simultaneous();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
